// File: rtl/mcdf_apb_pkg.sv
// Shared definitions for the MCDF APB register requester: state encoding,
// register map and reset values of the slave's register file.
package mcdf_apb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETUP = 2'b01,
        ACC   = 2'b10,
        RESP  = 2'b11
    } apb_state_e;

    localparam logic [7:0] SLV_EN      = 8'h00;
    localparam logic [7:0] ERR_CLR     = 8'h04;
    localparam logic [7:0] SLV_ID      = 8'h08;
    localparam logic [7:0] SLV_LEN     = 8'h0C;
    localparam logic [7:0] FREE_SLOT0  = 8'h80;
    localparam logic [7:0] FREE_SLOT1  = 8'h84;
    localparam logic [7:0] FREE_SLOT2  = 8'h88;
    localparam logic [7:0] FREE_SLOT3  = 8'h8C;
    localparam logic [7:0] PARITY_ERR0 = 8'h90;
    localparam logic [7:0] PARITY_ERR1 = 8'h94;
    localparam logic [7:0] PARITY_ERR2 = 8'h98;
    localparam logic [7:0] PARITY_ERR3 = 8'h9C;

    localparam logic [31:0] SLV_ID_RST = 32'h03020100;

endpackage

// File: rtl/apb_reg_master.sv
// APB requester: turns one command into one SETUP+ACCESS transfer and returns
// read data / error status, with a bounded wait on pready.
//
// state | meaning
// IDLE  | ready for a command; psel low
// SETUP | APB setup phase, one cycle
// ACC   | APB access phase, waits on pready or the timeout
// RESP  | response held until consumed; psel low (forms the inter-transfer gap)
module apb_reg_master
    import mcdf_apb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_wr_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              pwr_o,
    output logic              psel_o,
    output logic              pen_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    localparam bit TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    apb_state_e       state_q;
    apb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             to_hit;

    assign accept = (state_q == IDLE) && cmd_valid_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // pready is checked before the timeout so a late ready still completes normally
    always_comb begin
        state_d = state_q;
        to_hit  = 1'b0;
        case (state_q)
            IDLE:  if (cmd_valid_i) state_d = SETUP;
            SETUP: state_d = ACC;
            ACC: begin
                if (pready_i) begin
                    state_d = RESP;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    to_hit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:  if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            paddr_o       <= '0;
            pwr_o         <= 1'b0;
            pwdata_o      <= '0;
            cnt_q         <= '0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            if (accept) begin
                paddr_o  <= cmd_addr_i;
                pwr_o    <= cmd_wr_i;
                pwdata_o <= cmd_wdata_i;
                cnt_q    <= '0;
            end else if ((state_q == ACC) && !pready_i) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (state_q == ACC) begin
                if (pready_i) begin
                    rsp_rdata_o   <= (pwr_o || pslverr_i) ? '0 : prdata_i;
                    rsp_err_o     <= pslverr_i;
                    rsp_timeout_o <= 1'b0;
                end else if (to_hit) begin
                    rsp_rdata_o   <= '0;
                    rsp_err_o     <= 1'b1;
                    rsp_timeout_o <= 1'b1;
                end
            end
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign psel_o      = (state_q == SETUP) || (state_q == ACC);
    assign pen_o       = (state_q == ACC);
    assign rsp_valid_o = (state_q == RESP);

endmodule

// File: tb/tb_apb_reg_master.sv
// Directed bench for apb_reg_master with a small behavioural MCDF register slave.
module tb_apb_reg_master;
    import mcdf_apb_pkg::*;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 4;
    localparam int CNT_W       = 8;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_wr_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;
    logic              rsp_timeout_o;
    logic [ADDR_W-1:0] paddr_o;
    logic              pwr_o;
    logic              psel_o;
    logic              pen_o;
    logic [DATA_W-1:0] pwdata_o;
    logic [DATA_W-1:0] prdata_i;
    logic              pready_i;
    logic              pslverr_i;

    always #5 clk_i = ~clk_i;

    apb_reg_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .paddr_o(paddr_o), .pwr_o(pwr_o), .psel_o(psel_o), .pen_o(pen_o),
        .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    // slave model: 0x40..0x7F answer with pslverr, wait_n stalls, hang never answers
    logic [3:0] slv_en;
    logic [7:0] slv_len;
    logic [5:0] free_slot [4];
    int         acc_cyc;
    int         wait_n;
    logic       hang;
    logic       acc_phase;

    assign acc_phase = psel_o && pen_o;
    assign pready_i  = acc_phase && !hang && (acc_cyc >= wait_n);
    assign pslverr_i = acc_phase && (paddr_o >= 8'h40) && (paddr_o < 8'h80);

    always_comb begin
        prdata_i = 32'hDEAD_BEEF;
        case (paddr_o)
            SLV_EN:     prdata_i = {28'd0, slv_en};
            SLV_ID:     prdata_i = SLV_ID_RST;
            SLV_LEN:    prdata_i = {24'd0, slv_len};
            FREE_SLOT0: prdata_i = {26'd0, free_slot[0]};
            FREE_SLOT1: prdata_i = {26'd0, free_slot[1]};
            FREE_SLOT2: prdata_i = {26'd0, free_slot[2]};
            FREE_SLOT3: prdata_i = {26'd0, free_slot[3]};
            default:    prdata_i = 32'hDEAD_BEEF;
        endcase
    end

    always @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc_cyc <= 0;
            slv_en  <= 4'h0;
            slv_len <= 8'h00;
        end else begin
            acc_cyc <= (acc_phase && !pready_i) ? acc_cyc + 1 : 0;
            if (acc_phase && pready_i && pwr_o && !pslverr_i) begin
                case (paddr_o)
                    SLV_EN:  slv_en  <= pwdata_o[3:0];
                    SLV_LEN: slv_len <= pwdata_o[7:0];
                    default: ;
                endcase
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issues one command from IDLE with rsp_ready high and returns once back in IDLE.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output logic to,
                        output int lat, output int acc_n);
        bit seen;
        seen  = 0;
        lat   = 0;
        acc_n = 0;
        rdata = '0;
        err   = 1'b0;
        to    = 1'b0;
        check("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1;
        cmd_wr_i    = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            lat++;
            cmd_valid_i = 1'b0;
            if (lat == 1) begin
                check("setup_phase", 32'({psel_o, pen_o}), 32'b10);
                check("setup_addr", 32'({pwr_o, paddr_o}), 32'({wr, addr}));
            end
            if (psel_o && pen_o) acc_n++;
            if (rsp_valid_o) begin
                seen  = 1;
                rdata = rsp_rdata_o;
                err   = rsp_err_o;
                to    = rsp_timeout_o;
                check("resp_psel_pen", 32'({psel_o, pen_o, cmd_ready_o}), 32'b000);
            end
        end
        check("rsp_seen", 32'(seen), 32'd1);
        tick();
    endtask

    logic [31:0] rd;
    logic        er;
    logic        tmo;
    int          lat;
    int          accn;
    int          seen_cnt;

    initial begin
        #200000;
        $display("FAIL watchdog got=expired exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid_i  = 1'b0;
        cmd_wr_i     = 1'b0;
        cmd_addr_i   = '0;
        cmd_wdata_i  = '0;
        rsp_ready_i  = 1'b1;
        wait_n       = 0;
        hang         = 1'b0;
        free_slot[0] = 6'd32;
        free_slot[1] = 6'd5;
        free_slot[2] = 6'd0;
        free_slot[3] = 6'd63;
        rst_n_i      = 1'b1;
        #2 rst_n_i   = 1'b0;
        #2;
        check("rst_apb_ctl", 32'({psel_o, pen_o, pwr_o}), 32'd0);
        check("rst_paddr", 32'(paddr_o), 32'd0);
        check("rst_pwdata", pwdata_o, 32'd0);
        check("rst_rsp_ctl", 32'({rsp_valid_o, rsp_err_o, rsp_timeout_o}), 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        tick();
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);

        // write SLV_EN, zero-wait slave
        xfer(1'b1, SLV_EN, 32'h0000_000F, rd, er, tmo, lat, accn);
        check("wr_lat", 32'(lat), 32'd3);
        check("wr_acc_n", 32'(accn), 32'd1);
        check("wr_rsp", {rd[29:0], er, tmo}, 32'd0);
        check("wr_slv_en", 32'(slv_en), 32'hF);
        xfer(1'b0, SLV_EN, 32'h0, rd, er, tmo, lat, accn);
        check("rd_slv_en", rd, 32'h0000_000F);

        // register reads
        xfer(1'b0, SLV_ID, 32'h0, rd, er, tmo, lat, accn);
        check("rd_id", rd, 32'h0302_0100);
        check("rd_id_err", 32'({er, tmo}), 32'd0);
        xfer(1'b0, FREE_SLOT0, 32'h0, rd, er, tmo, lat, accn);
        check("rd_free0", rd, 32'h0000_0020);
        xfer(1'b0, FREE_SLOT3, 32'h0, rd, er, tmo, lat, accn);
        check("rd_free3", rd, 32'h0000_003F);

        // slave error, read and write
        xfer(1'b0, 8'h40, 32'h0, rd, er, tmo, lat, accn);
        check("slverr_rd_flags", 32'({er, tmo}), 32'b10);
        check("slverr_rd_data", rd, 32'd0);
        xfer(1'b1, 8'h7C, 32'h1234_5678, rd, er, tmo, lat, accn);
        check("slverr_wr_flags", 32'({er, tmo}), 32'b10);
        check("slverr_wr_data", rd, 32'd0);

        // hung slave: exactly TIMEOUT_CYC access cycles
        hang = 1'b1;
        xfer(1'b0, SLV_ID, 32'h0, rd, er, tmo, lat, accn);
        check("to_lat", 32'(lat), 32'd6);
        check("to_acc_n", 32'(accn), 32'd4);
        check("to_flags", 32'({er, tmo}), 32'b11);
        check("to_data", rd, 32'd0);
        hang = 1'b0;

        // pready on the threshold cycle completes normally
        wait_n = 3;
        xfer(1'b0, SLV_ID, 32'h0, rd, er, tmo, lat, accn);
        check("edge_lat", 32'(lat), 32'd6);
        check("edge_acc_n", 32'(accn), 32'd4);
        check("edge_flags", 32'({er, tmo}), 32'b00);
        check("edge_data", rd, 32'h0302_0100);
        wait_n = 2;
        xfer(1'b0, FREE_SLOT1, 32'h0, rd, er, tmo, lat, accn);
        check("wait2_lat", 32'(lat), 32'd5);
        check("wait2_data", rd, 32'h0000_0005);
        wait_n = 0;

        // back-pressured response with a queued second command
        rsp_ready_i = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_wr_i    = 1'b1;
        cmd_addr_i  = SLV_LEN;
        cmd_wdata_i = 32'h0000_00A5;
        tick();
        cmd_wr_i    = 1'b0;
        cmd_wdata_i = 32'hFFFF_FFFF;
        tick();
        tick();
        check("bp_resp_enter", 32'({rsp_valid_o, psel_o, cmd_ready_o}), 32'b100);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {rsp_valid_o, psel_o, pen_o, cmd_ready_o, rsp_err_o, rsp_rdata_o[26:0]},
                  32'h8000_0000);
        end
        check("bp_slv_len", 32'(slv_len), 32'hA5);
        rsp_ready_i = 1'b1;
        tick();
        check("bp_gap_idle", 32'({rsp_valid_o, psel_o, cmd_ready_o}), 32'b001);
        tick();
        cmd_valid_i = 1'b0;
        check("bp_second_setup", 32'({psel_o, pen_o, pwr_o, paddr_o}), 32'({3'b100, SLV_LEN}));
        seen_cnt = 0;
        for (int i = 0; i < 10 && seen_cnt == 0; i++) begin
            tick();
            if (rsp_valid_o) begin
                seen_cnt = 1;
                check("bp_second_data", rsp_rdata_o, 32'h0000_00A5);
            end
        end
        check("bp_second_seen", 32'(seen_cnt), 32'd1);
        tick();

        // reset while in ACC
        hang        = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_wr_i    = 1'b0;
        cmd_addr_i  = SLV_ID;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        check("mid_acc", 32'({psel_o, pen_o}), 32'b11);
        #2 rst_n_i = 1'b0;
        #1;
        check("mid_rst_drop", 32'({psel_o, pen_o, rsp_valid_o}), 32'd0);
        tick();
        tick();
        hang    = 1'b0;
        rst_n_i = 1'b1;
        seen_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid_o || psel_o) seen_cnt++;
        end
        check("post_rst_quiet", 32'(seen_cnt), 32'd0);
        xfer(1'b0, SLV_ID, 32'h0, rd, er, tmo, lat, accn);
        check("post_rst_lat", 32'(lat), 32'd3);
        check("post_rst_data", rd, 32'h0302_0100);
        check("post_rst_flags", 32'({er, tmo}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_reg_master.md
Name: apb_reg_master

Overview:
- APB requester that drives the MCDF register-interface slave from a simple command/response channel.
- Used by the on-chip config sequencer and the SoC bridge to program slv_en/err_clr/id/len and read free-slot and parity registers.
- Converts one command into one APB SETUP+ACCESS transfer and returns read data and error status.
- Adds a bounded-wait timeout so a hung slave cannot stall the requester.

Parameters:
- ADDR_W, 8, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYC, 16, ACCESS cycles with pready low before abort; 0 disables the timeout.
- CNT_W, 8, timeout counter width; must satisfy TIMEOUT_CYC < 2**CNT_W.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_wr_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_W  register byte address
- cmd_wdata_i  in  DATA_W  write data
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  DATA_W  read data (0 for writes/errors)
- rsp_err_o  out  1  pslverr or timeout
- rsp_timeout_o  out  1  abort caused by timeout
- paddr_o  out  ADDR_W  APB address
- pwr_o  out  1  APB write
- psel_o  out  1  APB select
- pen_o  out  1  APB enable
- pwdata_o  out  DATA_W  APB write data
- prdata_i  in  DATA_W  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

Interface:
- One clock, clk_i.
- Reset rst_n_i is asynchronous and active-low.

Behaviour:
- FSM states: IDLE, SETUP, ACC, RESP. All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to APB outputs.
- Reset values:
  - state=IDLE.
  - psel_o=pen_o=pwr_o=0.
  - paddr_o=0, pwdata_o=0.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, rsp_timeout_o=0.
  - Timeout counter=0.
  - cmd_ready_o=1 once out of reset.
- IDLE:
  - cmd_ready_o=1, psel_o=0, pen_o=0.
  - On cmd_valid_i: latch addr/wr/wdata into paddr_o/pwr_o/pwdata_o, go to SETUP.
- SETUP (exactly 1 cycle):
  - psel_o=1, pen_o=0, cmd_ready_o=0.
  - Unconditionally go to ACC.
- ACC:
  - psel_o=1, pen_o=1. paddr/pwr/pwdata are held stable.
  - On pready_i=1: capture rsp_rdata_o = pwr_o ? 0 : prdata_i; rsp_err_o=pslverr_i; rsp_timeout_o=0; rsp_rdata_o is forced to 0 if pslverr_i. Go to RESP.
  - If pready_i=0: increment the counter. If TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1, set rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0, and go to RESP.
  - Counter clears on entry to SETUP.
- RESP:
  - psel_o=0, pen_o=0, rsp_valid_o=1, cmd_ready_o=0.
  - Response fields are held stable until rsp_ready_i=1, then go to IDLE and clear rsp_valid_o.
- Inter-transfer gap:
  - psel_o is low for at least 2 cycles (RESP + IDLE) between transfers.
  - This is mandatory: the MCDF slave captures the address only on an IDLE->SETUP transition and drops to IDLE after ACC.
  - Back-to-back SETUP after ACC is forbidden.
- Latency:
  - Command accepted at edge T gives SETUP in T+1 and ACC in T+2.
  - With a zero-wait slave, rsp_valid_o=1 in T+3.
  - Minimum command-to-command period is 4 cycles.
- APB outputs change only on the SETUP entry edge (address/data) and the SETUP/ACC/RESP edges (psel/pen).
- Simultaneous pready_i=1 and the timeout threshold in the same cycle: pready wins (normal completion, no timeout).
- Reset mid-transfer: psel_o/pen_o drop asynchronously, the in-flight response is discarded, and no rsp_valid_o is issued.
- cmd_valid_i outside IDLE is ignored (not accepted); the requester must hold it.

Decomposition:
- Shared package mcdf_apb_pkg holds:
  - FSM state encoding (IDLE=2'b00, SETUP=2'b01, ACC=2'b10, RESP=2'b11).
  - Register address constants: SLV_EN=8'h00, ERR_CLR=8'h04, SLV_ID=8'h08, SLV_LEN=8'h0C, FREE_SLOT0..3=8'h80..8'h8C, PARITY_ERR0..3=8'h90..8'h9C.
  - Reset value SLV_ID_RST=32'h03020100.
- Single module, no sub-module; the timeout counter is inline.

Test Plan:
1. Write 0x00 ← 0x0000000F, rsp_ready tied 1 → SETUP at T+1, ACC at T+2, rsp_valid at T+3 with err=0; slave slv_en_o=4'hF.
2. After reset, read 0x08 → rsp_rdata_o=32'h03020100, err=0; then read 0x80 with slv0_free_slot=6'd32 → rdata=32'h00000020.
3. Read 0x40 (slave error range) → rsp_err_o=1, rsp_timeout_o=0, rsp_rdata_o=0.
4. TIMEOUT_CYC=4, pready tied 0 → ACC for exactly 4 cycles (T+2..T+5), rsp_valid at T+6 with err=1, timeout=1, psel_o=0.
5. Two queued commands with rsp_ready low for 5 cycles → response held stable, cmd_ready_o=0, second SETUP only after the handshake, psel_o low for ≥2 cycles between transfers.
6. Assert rst_n_i low during ACC → psel_o/pen_o=0 immediately, no rsp_valid; first post-reset command completes normally.
